// File: rtl/match_event_logger_pkg.sv
// Shared defaults for the match event logger and its timestamp FIFO.
package match_event_logger_pkg;

  localparam int unsigned TS_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned LVL_W_DEF = $clog2(DEPTH_DEF) + 1;

endpackage

// File: rtl/match_event_logger_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word, valid flag and level.
module sync_fifo
  import match_event_logger_pkg::*;
#(
  parameter int unsigned W     = TS_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_nxt;
  logic          do_pop;
  logic          do_push;

  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;

  always_comb begin
    do_pop    = pop && (level_q != '0);
    do_push   = push && (!full || do_pop);
    level_nxt = level_q;
    if (do_push && !do_pop)
      level_nxt = level_q + 1'b1;
    else if (!do_push && do_pop)
      level_nxt = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // dout mirrors mem[rd_ptr] one edge ahead so the head is a plain register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      dout    <= '0;
      valid   <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_nxt;
      valid   <= (level_nxt != '0);
      if (do_pop) begin
        if (level_q == LW'(1)) begin
          if (do_push)
            dout <= din;
        end else begin
          dout <= mem[rd_ptr + 1'b1];
        end
      end else if (level_q == '0 && do_push) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/match_event_logger.sv
// Timestamps accepted match pulses into a FIFO drained by valid/ready, with a
// saturating match counter and sticky overflow flag.
module match_event_logger
  import match_event_logger_pkg::*;
#(
  parameter int unsigned TS_W  = TS_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     match_in,
  input  logic                     en,
  input  logic                     clr_ovf,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [TS_W-1:0]          evt_ts,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         match_count,
  output logic                     overflow
);

  logic [TS_W-1:0] ts;
  logic            accepted;
  logic            popping;
  logic            full;
  logic            drop;

  assign accepted = match_in & en;
  assign popping  = evt_valid & evt_ready;
  assign drop     = accepted & full & ~popping;

  sync_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accepted),
    .din   (ts),
    .pop   (evt_ready),
    .dout  (evt_ts),
    .valid (evt_valid),
    .full  (full),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ts          <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (accepted && match_count != '1)
        match_count <= match_count + 1'b1;
      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_match_event_logger.sv
// Directed plus randomized bench for match_event_logger against a queue-based model.
module tb_match_event_logger;

  localparam int unsigned TS_W  = 6;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              match_in = 1'b0;
  logic              en = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              evt_ready = 1'b0;
  logic              evt_valid;
  logic [TS_W-1:0]   evt_ts;
  logic [LW-1:0]     fifo_level;
  logic [CNT_W-1:0]  match_count;
  logic              overflow;

  match_event_logger #(
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .match_in    (match_in),
    .en          (en),
    .clr_ovf     (clr_ovf),
    .evt_ready   (evt_ready),
    .evt_valid   (evt_valid),
    .evt_ts      (evt_ts),
    .fifo_level  (fifo_level),
    .match_count (match_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of logged timestamps plus counters.
  int unsigned m_ts  = 0;
  int unsigned q[$];
  int unsigned m_cnt = 0;
  bit          m_ovf = 0;
  bit          chk_on = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ts  = 0;
      q.delete();
      m_cnt = 0;
      m_ovf = 0;
    end else begin
      int unsigned sz;
      bit p, acc, dropped;
      sz      = q.size();
      p       = (sz > 0) && evt_ready;
      acc     = match_in && en;
      dropped = 0;
      if (p) void'(q.pop_front());
      if (acc) begin
        if (sz == DEPTH && !p) dropped = 1;
        else q.push_back(m_ts);
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      if (dropped) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", evt_valid, q.size() != 0);
      chk("level", fifo_level, q.size());
      chk("count", match_count, m_cnt);
      chk("overflow", overflow, m_ovf);
      if (q.size() != 0) chk("head_ts", evt_ts, q[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; match_in = 0; en = 1; clr_ovf = 0; evt_ready = 0;
    step();
    rst = 0;
  endtask

  task automatic pulse();
    match_in = 1;
    step();
    match_in = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned seq[$];
    int unsigned ready_pct;

    @(negedge clk);
    do_reset();
    chk_on = 1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_ts", evt_ts, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_count", match_count, 0);
    chk("rst_ovf", overflow, 0);

    // Single pulse at ts=5, then one pop.
    repeat (5) step();
    pulse();
    chk("t1_valid", evt_valid, 1);
    chk("t1_ts", evt_ts, 5);
    chk("t1_level", fifo_level, 1);
    chk("t1_count", match_count, 1);
    evt_ready = 1;
    step();
    evt_ready = 0;
    chk("t1_pop_valid", evt_valid, 0);
    chk("t1_pop_level", fifo_level, 0);

    // Pulses at ts 3,4,10 with continuous ready.
    do_reset();
    evt_ready = 1;
    for (int c = 0; c < 14; c++) begin
      match_in = (c == 3 || c == 4 || c == 10);
      if (evt_valid) seq.push_back(evt_ts);
      step();
    end
    match_in = 0;
    evt_ready = 0;
    chk("t2_len", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("t2_e0", seq[0], 3);
      chk("t2_e1", seq[1], 4);
      chk("t2_e2", seq[2], 10);
    end
    chk("t2_count", match_count, 3);
    chk("t2_ovf", overflow, 0);

    // Overfill from ts=20, drain in order, clear overflow.
    do_reset();
    repeat (20) step();
    match_in = 1;
    repeat (10) step();
    match_in = 0;
    chk("t3_level", fifo_level, 8);
    chk("t3_ovf", overflow, 1);
    chk("t3_count", match_count, 10);
    evt_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", evt_ts, 20 + i);
      step();
    end
    evt_ready = 0;
    chk("t3_empty", fifo_level, 0);
    chk("t3_ovf_held", overflow, 1);
    clr_ovf = 1;
    step();
    clr_ovf = 0;
    chk("t3_clr", overflow, 0);

    // Full FIFO, push coincident with pop.
    do_reset();
    match_in = 1;
    repeat (8) step();
    evt_ready = 1;
    step();
    match_in = 0;
    chk("t4_level", fifo_level, 8);
    chk("t4_ovf", overflow, 0);
    repeat (7) step();
    evt_ready = 0;
    chk("t4_last", evt_ts, 8);
    chk("t4_level1", fifo_level, 1);

    // Enable gating.
    do_reset();
    en = 0;
    repeat (4) begin
      pulse();
      step();
    end
    chk("t5_level", fifo_level, 0);
    chk("t5_count", match_count, 0);
    en = 1;
    pulse();
    chk("t5_count1", match_count, 1);

    // Reset mid-drain.
    do_reset();
    match_in = 1;
    repeat (3) step();
    match_in = 0;
    evt_ready = 1;
    step();
    evt_ready = 0;
    rst = 1;
    step();
    rst = 0;
    chk("t6_valid", evt_valid, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_count", match_count, 0);
    chk("t6_ts", evt_ts, 0);
    repeat (2) step();
    pulse();
    chk("t6_post_valid", evt_valid, 1);
    chk("t6_post_ts", evt_ts, 2);

    // Randomized traffic; the per-cycle compare process checks everything.
    ready_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) ready_pct = $urandom_range(0, 100);
      en        = ($urandom_range(0, 7) != 0);
      match_in  = ($urandom_range(0, 99) < 60);
      evt_ready = ($urandom_range(0, 99) < ready_pct);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 0; match_in = 0; evt_ready = 0; clr_ovf = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
